decoder38_hold: RTL and testbench
=================================

Name: decoder38_hold

Overview:
- Registered 3-to-8 decoder: the inverse of the team's 8-to-3 encoder.
- Accepts a 3-bit code through a valid/ready handshake and drives the matching one-hot 8-bit output for a programmable number of cycles.
- Returns to all-zero output afterwards.
- Sits between control logic and one-hot consumers (LED rows, digit selects, channel enables); lets the encoder/decoder pair be looped back in test.

Parameters:
- HOLD_CYCLES, 4: cycles each decoded one-hot value is held on oData; 0 is treated as 1.
- CNT_W, 8: hold counter width; HOLD_CYCLES-1 must fit in CNT_W bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iValid  input  1  iCode valid this cycle.
- iCode  input  3  binary code to decode.
- oReady  output  1  block accepts iCode this cycle.
- oData  output  8  one-hot decoded value; 8'b0 when idle.
- oBusy  output  1  high while in HOLD.
- oDone  output  1  one-cycle pulse when a hold ends without a back-to-back accept.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0 all outputs take their reset values immediately:
  - state=IDLE, cnt=0
  - oData=8'b0, oBusy=0, oDone=0
  - oReady=0 during reset, 1 in the first cycle after release.
- Accept: on a clk edge with iValid=1 and oReady=1.
- oReady is combinational from state: 1 in IDLE; 1 in HOLD when cnt==0; otherwise 0.
- IDLE:
  - oData=0, oBusy=0.
  - On accept: oData <= 8'b1 << iCode; cnt <= HOLD_CYCLES-1; state <= HOLD.
  - Latency: one cycle from the accept edge to oData valid.
- HOLD:
  - oData stays constant; oBusy=1; cnt decrements once per cycle while cnt!=0.
  - cnt==0 with accept (back-to-back): oData <= 8'b1 << iCode, cnt reloads, stay in HOLD, no oDone, no zero gap between codes.
  - cnt==0 without accept: state <= IDLE, oData <= 0, oDone <= 1 for exactly one cycle.
- oData is held for exactly HOLD_CYCLES cycles per accepted code.
- HOLD_CYCLES=1: oReady=1 every cycle. A continuous stream updates oData every cycle; oDone fires only when the stream stops.
- iValid while oReady=0 is ignored (not queued). The source must hold iValid/iCode until accepted.
- iCode is sampled only on accept; changes at other times have no effect.
- oData is always either 0 or exactly one bit set; never multi-hot.
- Reset mid-hold: outputs clear asynchronously; the in-flight code is discarded; no oDone.

Optional Feature:
- Macro: DECODER38_ACTIVE_LOW_EN.
- Defined:
  - oData is driven as the bitwise inverse of the internal one-hot vector: idle/reset value 8'hFF, selected bit 0 (74x138-style).
  - Handshake, timing and oDone are unchanged.
- Undefined: active-high one-hot as described above.

Decomposition:
- Shared package (decoder38_pkg):
  - state encoding constants ST_IDLE=1'b0, ST_HOLD=1'b1
  - CODE_W=3, DATA_W=8
  - idle output constant (8'h00, or 8'hFF under the macro).
- Natural sub-module: decoder38_comb, a pure combinational 3-to-8 one-hot decode of a code. The top registers its result.
- Counter and FSM stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-run -> oData=8'h00, oBusy=0, oDone=0 immediately; after release oReady=1.
- Single code: HOLD_CYCLES=4, send iCode=3'd5 for one accepted cycle -> oData=8'b0010_0000 for exactly 4 cycles, then 8'h00; oDone high for 1 cycle; oReady low for the middle 3 hold cycles.
- Sweep: codes 0..7, each after the previous oDone -> oData=8'h01,02,04,...,80 in order, each held 4 cycles; never multi-hot.
- Back-to-back: hold iValid=1 with iCode=2 then 6 -> oData 8'h04 for 4 cycles immediately followed by 8'h40 for 4 cycles; no zero gap; a single oDone at the end.
- Ignored input: while busy, pulse iValid with iCode=7 for one cycle when oReady=0 -> no effect; oData unchanged; 8'h80 never appears.
- Loopback / macro: chain into encoder83 with HOLD_CYCLES=1 streaming 0..7 -> encoder output equals the delayed iCode. Rebuild with DECODER38_ACTIVE_LOW_EN and iCode=1 -> oData=8'hFD, idle 8'hFF.

Source files
------------

// File: rtl/decoder38_pkg.sv
// Shared types and constants for the registered 3-to-8 decoder.
// DECODER38_ACTIVE_LOW_EN selects an inverted (74x138-style) output polarity.
package decoder38_pkg;

  localparam int CODE_W = 3;
  localparam int DATA_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

`ifdef DECODER38_ACTIVE_LOW_EN
  localparam logic [DATA_W-1:0] IDLE_DATA = 8'hFF;
`else
  localparam logic [DATA_W-1:0] IDLE_DATA = 8'h00;
`endif

endpackage

// File: rtl/decoder38_comb.sv
// Pure combinational 3-to-8 one-hot decode; always exactly one bit set.
module decoder38_comb
  import decoder38_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/decoder38_hold.sv
// Registered 3-to-8 decoder holding each decoded code for HOLD_CYCLES cycles.
// Output polarity is inverted when DECODER38_ACTIVE_LOW_EN is defined.
module decoder38_hold
  import decoder38_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iValid,
  input  logic [CODE_W-1:0] iCode,
  output logic              oReady,
  output logic [DATA_W-1:0] oData,
  output logic              oBusy,
  output logic              oDone
);

  // A hold of zero cycles makes no sense; treat it as a single cycle.
  localparam int              HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(HOLD_EFF - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic                done_q, done_nxt;
  logic [DATA_W-1:0]   onehot;
  logic                accept;

  decoder38_comb u_comb (
    .code   (iCode),
    .onehot (onehot)
  );

  // Gated by rst_n so oReady reads low while reset is held.
  assign oReady = rst_n & ((state == ST_IDLE) | (cnt == '0));
  assign accept = iValid & oReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data_q <= data_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    done_nxt  = 1'b0;
    if (state == ST_IDLE) begin
      data_nxt = '0;
      if (accept) begin
        data_nxt  = onehot;
        cnt_nxt   = RELOAD;
        state_nxt = ST_HOLD;
      end
    end else begin
      if (cnt != '0) begin
        cnt_nxt = cnt - 1'b1;
      end else if (accept) begin
        data_nxt = onehot;
        cnt_nxt  = RELOAD;
      end else begin
        state_nxt = ST_IDLE;
        data_nxt  = '0;
        done_nxt  = 1'b1;
      end
    end
  end

  assign oData = data_q ^ IDLE_DATA;
  assign oBusy = (state == ST_HOLD);
  assign oDone = done_q;

endmodule

// File: tb/tb_decoder38_hold.sv
// Directed bench for decoder38_hold: one instance with a 4-cycle hold, one with a 1-cycle hold.
// Expectations follow DECODER38_ACTIVE_LOW_EN when the macro is defined.
module tb_decoder38_hold;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, valid1;
  logic [2:0] code, code1;
  logic       ready, ready1;
  logic [7:0] data, data1;
  logic       busy, busy1;
  logic       done, done1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decoder38_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk (clk), .rst_n (rst_n), .iValid (valid), .iCode (code),
    .oReady (ready), .oData (data), .oBusy (busy), .oDone (done)
  );

  decoder38_hold #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk (clk), .rst_n (rst_n), .iValid (valid1), .iCode (code1),
    .oReady (ready1), .oData (data1), .oBusy (busy1), .oDone (done1)
  );

  function automatic logic [7:0] pol(input logic [7:0] d);
`ifdef DECODER38_ACTIVE_LOW_EN
    return ~d;
`else
    return d;
`endif
  endfunction

  // Independent encoder83 model used for the loopback check.
  function automatic logic [3:0] enc83(input logic [7:0] d);
    case (d)
      8'h01: return 4'd0;
      8'h02: return 4'd1;
      8'h04: return 4'd2;
      8'h08: return 4'd3;
      8'h10: return 4'd4;
      8'h20: return 4'd5;
      8'h40: return 4'd6;
      8'h80: return 4'd7;
      default: return 4'hF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one code into dut, then follow it through its 4-cycle hold and oDone.
  task automatic send_and_hold(input logic [2:0] c, input logic [7:0] exp_oh);
    check("pre_ready", ready, 1'b1);
    valid = 1'b1;
    code  = c;
    tick();
    valid = 1'b0;
    code  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      check("hold_data", data, pol(exp_oh));
      check("hold_busy", busy, 1'b1);
      check("hold_ready", ready, (i == 3));
      check("hold_done", done, 1'b0);
      if (i < 3) tick();
    end
    tick();
    check("end_data", data, pol(8'h00));
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    tick();
    check("done_pulse", done, 1'b0);
  endtask

  logic [7:0] sweep_tbl [8];

  initial begin
    sweep_tbl[0] = 8'h01; sweep_tbl[1] = 8'h02; sweep_tbl[2] = 8'h04; sweep_tbl[3] = 8'h08;
    sweep_tbl[4] = 8'h10; sweep_tbl[5] = 8'h20; sweep_tbl[6] = 8'h40; sweep_tbl[7] = 8'h80;

    rst_n  = 1'b0;
    valid  = 1'b0;
    code   = 3'd0;
    valid1 = 1'b0;
    code1  = 3'd0;

    // Reset values while rst_n is low
    #3;
    check("rst_data", data, pol(8'h00));
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", ready, 1'b0);
    #9;
    rst_n = 1'b1;
    #1;
    check("rel_ready", ready, 1'b1);
    tick();

    // Single code 5
    send_and_hold(3'd5, 8'h20);

    // Sweep all codes
    for (int c = 0; c < 8; c++) send_and_hold(3'(c), sweep_tbl[c]);

    // Back-to-back 2 then 6
    valid = 1'b1;
    code  = 3'd2;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("b2b_first", data, pol(8'h04));
      check("b2b_done1", done, 1'b0);
      if (i == 3) code = 3'd6;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("b2b_second", data, pol(8'h40));
      check("b2b_done2", done, 1'b0);
      check("b2b_busy", busy, 1'b1);
      if (i == 3) valid = 1'b0;
      tick();
    end
    check("b2b_end_data", data, pol(8'h00));
    check("b2b_end_done", done, 1'b1);
    tick();
    check("b2b_done_pulse", done, 1'b0);

    // Ignored input while not ready
    valid = 1'b1;
    code  = 3'd3;
    tick();
    valid = 1'b0;
    check("ign_data0", data, pol(8'h08));
    check("ign_ready0", ready, 1'b0);
    valid = 1'b1;
    code  = 3'd7;
    tick();
    valid = 1'b0;
    code  = 3'd0;
    check("ign_data1", data, pol(8'h08));
    check("ign_ready1", ready, 1'b0);
    tick();
    check("ign_data2", data, pol(8'h08));
    tick();
    check("ign_data3", data, pol(8'h08));
    check("ign_ready3", ready, 1'b1);
    tick();
    check("ign_end_data", data, pol(8'h00));
    check("ign_end_done", done, 1'b1);
    tick();

    // Reset in the middle of a hold
    valid = 1'b1;
    code  = 3'd4;
    tick();
    valid = 1'b0;
    check("mid_data", data, pol(8'h10));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", data, pol(8'h00));
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_ready", ready, 1'b0);
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_no_done", done, 1'b0);
      check("mid_idle_data", data, pol(8'h00));
    end

    // Loopback through the encoder model with a 1-cycle hold stream
    check("s_pre_ready", ready1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      valid1 = 1'b1;
      code1  = 3'(c);
      tick();
      check("s_enc", enc83(pol(data1)), 4'(c));
      check("s_ready", ready1, 1'b1);
      check("s_busy", busy1, 1'b1);
      check("s_done", done1, 1'b0);
    end
    valid1 = 1'b0;
    tick();
    check("s_end_data", data1, pol(8'h00));
    check("s_end_done", done1, 1'b1);
    tick();
    check("s_done_pulse", done1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
